// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants, note field layout and state encoding for the tone generator
package tone_pkg;

  localparam int SEMITONES = 12;
  localparam int MAX_SEMI  = SEMITONES - 1;

  // C4..B4 in milli-Hz
  localparam int FREQ_MHZ [SEMITONES] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883
  };

  localparam int NOTE_REST_BIT = 7;
  localparam int NOTE_OCT_LSB  = 4;
  localparam int NOTE_SEMI_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    REST = 2'd2
  } toneState_t;

endpackage

// File: rtl/tone_div.sv
// rtl/tone_div.sv - loadable down-counter that flags its terminal count
module tone_div #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] loadVal,
  output logic         term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign term = en && (cnt == '0);

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave note synthesiser with valid/ack command capture
module tone_gen
  import tone_pkg::*;
#(
  parameter int C_CLK_FRQ   = 100_000_000,
  parameter int C_MUSIC     = 500,
  parameter int C_CNT_WIDTH = 24
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       valid,
  input  logic [7:0] note,
  output logic       ack,
  output logic       err,
  output logic       audio,
  output logic       playing,
  output logic       done
);

  function automatic longint calcHalf(input int s);
    return (longint'(C_CLK_FRQ) * 64'sd1000) / (64'sd2 * longint'(FREQ_MHZ[s]));
  endfunction

  localparam longint HALF_TBL [SEMITONES] = '{
    calcHalf(0), calcHalf(1), calcHalf(2),  calcHalf(3),
    calcHalf(4), calcHalf(5), calcHalf(6),  calcHalf(7),
    calcHalf(8), calcHalf(9), calcHalf(10), calcHalf(11)
  };

  localparam longint D_CYC     = longint'(C_CLK_FRQ) / 64'sd1000 * longint'(C_MUSIC);
  localparam longint CNT_LIMIT = longint'(1) << C_CNT_WIDTH;

  if ((D_CYC - 1) >= CNT_LIMIT || (HALF_TBL[0] - 1) >= CNT_LIMIT) begin : gWidthCheck
    $fatal(1, "tone_gen: C_CNT_WIDTH too small for note duration or lowest half-period");
  end

  typedef logic [C_CNT_WIDTH-1:0] cnt_t;

  toneState_t state, nextState;
  logic       audioNext, ackNext, errNext, doneNext;
  cnt_t       halfReg, halfNext, newHalf, phaseLoadVal;
  logic       phaseLoad, phaseTerm, durLoad, durTerm;
  logic       capture, badSemi, isRest;
  logic [3:0] semi, semiIdx;
  logic [1:0] octave;
  logic       unusedNoteBit;

  assign unusedNoteBit = note[6];

  assign capture = valid && !ack;
  assign semi    = note[NOTE_SEMI_LSB +: 4];
  assign octave  = note[NOTE_OCT_LSB +: 2];
  assign isRest  = note[NOTE_REST_BIT];
  assign badSemi = semi > 4'(MAX_SEMI);
  assign semiIdx = badSemi ? 4'd0 : semi;
  assign newHalf = C_CNT_WIDTH'(HALF_TBL[semiIdx] >> octave);
  assign playing = (state != IDLE);

  tone_div #(.W(C_CNT_WIDTH)) uPhase (
    .clk     (clk),
    .rstb    (rstb),
    .load    (phaseLoad),
    .en      (state == TONE),
    .loadVal (phaseLoadVal),
    .term    (phaseTerm)
  );

  tone_div #(.W(C_CNT_WIDTH)) uDur (
    .clk     (clk),
    .rstb    (rstb),
    .load    (durLoad),
    .en      (state != IDLE),
    .loadVal (C_CNT_WIDTH'(D_CYC - 1)),
    .term    (durTerm)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      audio   <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      halfReg <= '0;
    end else begin
      state   <= nextState;
      audio   <= audioNext;
      ack     <= ackNext;
      err     <= errNext;
      done    <= doneNext;
      halfReg <= halfNext;
    end
  end

  // A valid capture outranks expiry, so a retrigger on the last cycle yields no done
  always_comb begin
    nextState    = state;
    audioNext    = audio;
    ackNext      = capture;
    errNext      = capture && badSemi;
    doneNext     = 1'b0;
    halfNext     = halfReg;
    phaseLoad    = 1'b0;
    phaseLoadVal = halfReg - cnt_t'(1);
    durLoad      = 1'b0;
    if (capture && !badSemi) begin
      durLoad = 1'b1;
      if (isRest) begin
        nextState = REST;
        audioNext = 1'b0;
      end else begin
        nextState    = TONE;
        audioNext    = 1'b1;
        halfNext     = newHalf;
        phaseLoad    = 1'b1;
        phaseLoadVal = newHalf - cnt_t'(1);
      end
    end else if (state != IDLE && durTerm) begin
      nextState = IDLE;
      audioNext = 1'b0;
      doneNext  = 1'b1;
    end else if (state == TONE && phaseTerm) begin
      audioNext = !audio;
      phaseLoad = 1'b1;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - self-checking bench for tone_gen at 1 MHz clock, 1 ms notes
module tb_tone_gen;

  localparam int D = 1000;

  logic       clk = 1'b0;
  logic       rstb, valid;
  logic [7:0] note;
  logic       ack, err, audio, playing, done;

  int vecCount  = 0;
  int missCount = 0;

  int freqTbl [12] = '{261626, 277183, 293665, 311127, 329628, 349228,
                       369994, 391995, 415305, 440000, 466164, 493883};

  typedef struct {
    logic [7:0] n;
    int         half;
    bit         isErr;
    bit         isRest;
  } vec_t;

  vec_t vecs [8];

  tone_gen #(.C_CLK_FRQ(1_000_000), .C_MUSIC(1), .C_CNT_WIDTH(24)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .valid   (valid),
    .note    (note),
    .ack     (ack),
    .err     (err),
    .audio   (audio),
    .playing (playing),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {ack, err, audio, playing, done};
  endfunction

  function automatic int modelHalf(input logic [7:0] n);
    int s;
    int oct;
    s   = int'(n[3:0]);
    oct = int'(n[5:4]);
    return (1000000000 / (2 * freqTbl[s])) >> oct;
  endfunction

  task automatic cmp(input string name, input int t, input logic [4:0] got, input logic [4:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s t=%0d ack/err/audio/playing/done got=%b expected=%b", name, t, got, exp);
    end
  endtask

  task automatic capture(input logic [7:0] n);
    @(negedge clk);
    valid = 1'b1;
    note  = n;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Expected outputs for cycle k+t after a capture at edge k, starting from IDLE or a running note
  task automatic checkRun(input string name, input int half, input bit isErr, input bit isRest, input int nCycles);
    for (int t = 1; t <= nCycles; t++) begin
      logic [4:0] e;
      @(negedge clk);
      e[4] = (t == 1);
      e[3] = (t == 1) && isErr;
      if (isErr) begin
        e[2:0] = 3'b000;
      end else begin
        e[2] = !isRest && (t <= D) && (((t - 1) / half) % 2 == 0);
        e[1] = (t <= D);
        e[0] = (t == D + 1);
      end
      cmp(name, t, outs(), e);
    end
  endtask

  task automatic checkIdle(input string name, input int nCycles);
    for (int t = 1; t <= nCycles; t++) begin
      @(negedge clk);
      cmp(name, t, outs(), 5'b00000);
    end
  endtask

  initial begin
    rstb  = 1'b0;
    valid = 1'b0;
    note  = 8'h00;

    vecs[0] = '{8'h09, 1136, 1'b0, 1'b0};
    vecs[1] = '{8'h10,  955, 1'b0, 1'b0};
    vecs[2] = '{8'h80,    1, 1'b0, 1'b1};
    vecs[3] = '{8'h0C,    1, 1'b1, 1'b0};
    vecs[4] = '{8'h3B,  126, 1'b0, 1'b0};
    vecs[5] = '{8'h40, 1911, 1'b0, 1'b0};
    vecs[6] = '{8'h25,  357, 1'b0, 1'b0};
    vecs[7] = '{8'hCF,    1, 1'b1, 1'b0};

    #12;
    cmp("reset", 0, outs(), 5'b00000);
    @(negedge clk);
    rstb = 1'b1;
    checkIdle("idleAfterReset", 3);

    foreach (vecs[i]) begin
      capture(vecs[i].n);
      checkRun($sformatf("vec%0d_%h", i, vecs[i].n), vecs[i].half, vecs[i].isErr, vecs[i].isRest,
               vecs[i].isErr ? 5 : D + 1);
      checkIdle("gap", 2);
    end

    for (int r = 0; r < 6; r++) begin
      logic [7:0] n;
      bit         e;
      n = 8'($urandom);
      e = n[3:0] > 4'd11;
      capture(n);
      checkRun($sformatf("rand%0d_%h", r, n), e ? 1 : modelHalf(n), e, n[7] && !e, e ? 5 : D + 1);
      checkIdle("randGap", 2);
    end

    capture(8'h09);
    checkRun("retrigFirst", 1136, 1'b0, 1'b0, 500);
    capture(8'h00);
    checkRun("retrigSecond", 1911, 1'b0, 1'b0, D + 1);
    checkIdle("retrigGap", 2);

    capture(8'h25);
    checkRun("expiryRaceFirst", 357, 1'b0, 1'b0, D - 1);
    capture(8'h80);
    checkRun("expiryRaceSecond", 1, 1'b0, 1'b1, D + 1);
    checkIdle("raceGap", 2);

    capture(8'h09);
    checkRun("preReset", 1136, 1'b0, 1'b0, 300);
    capture(8'h09);
    checkRun("ackBeforeReset", 1136, 1'b0, 1'b0, 1);
    #2 rstb = 1'b0;
    #1 cmp("asyncReset", 0, outs(), 5'b00000);
    @(negedge clk);
    rstb = 1'b1;
    checkIdle("afterReset", D + 20);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
